quickq_ctrl_node: RTL and testbench
===================================

Name: quickq_ctrl_node

Overview:
Parametrised control node for one QuickQ priority-queue stage, and the successor to the single-width stage controller.
- Owns a DEPTH-entry sorted min-array held in an external synchronous RAM. Head at address 0 is the smallest key.
- Sequences insertion-sort shifts on enqueue and compaction shifts on dequeue.
- Evicts the largest key to the next stage when full, and refills its tail from the next stage after a dequeue.
- Stages chain by wiring one node's dn_* ports to the next node's up_* ports.

Parameters:
DATA_W, 16, key width in bits
DEPTH, 8, entries per node; must be at least 2
ADDR_W, $clog2(DEPTH), RAM address width (derived, not overridden)
CHAIN_LAST, 0, 1 = no downstream node: overflow keys are dropped and there is no refill

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
up_write_i  in  1  enqueue request
up_key_i  in  DATA_W  key to enqueue
up_read_i  in  1  dequeue request
up_ready_o  out  1  node idle; a request is accepted when request && up_ready_o
up_rd_valid_o  out  1  one-cycle pulse: dequeued key valid
up_rd_key_o  out  DATA_W  dequeued key
dn_write_o  out  1  evict request to the next node, held until dn_ready_i
dn_key_o  out  DATA_W  evicted key
dn_read_o  out  1  refill request, held until dn_ready_i
dn_ready_i  in  1  next node idle
dn_rd_valid_i  in  1  refill key valid
dn_rd_key_i  in  DATA_W  refill key
dn_empty_i  in  1  next node empty
mem_rd_en_o  out  1  RAM read enable; data returns on mem_rdata_i the next cycle
mem_rd_addr_o  out  ADDR_W  RAM read address
mem_rdata_i  in  DATA_W  RAM read data
mem_wr_en_o  out  1  RAM write enable
mem_wr_addr_o  out  ADDR_W  RAM write address
mem_wdata_o  out  DATA_W  RAM write data
count_o  out  ADDR_W+1  occupancy
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
drop_o  out  1  one-cycle pulse: key discarded (CHAIN_LAST=1 only)

Behaviour:
Reset:
- All outputs 0 except empty_o=1 and up_ready_o=1.
- FSM returns to IDLE and count is set to 0.
- Reset asserted mid-operation aborts immediately; handshake outputs fall asynchronously. RAM contents are don't-care.

FSM states: IDLE, EVICT_RD, EVICT, INS_RD, INS_SCAN, INS_WR, DEQ_RD, DEQ_SHIFT, DEQ_FILL.
- up_ready_o=1 only in IDLE.
- If up_read_i and up_write_i are both asserted, the read wins and the write stays pending.
- up_read_i while empty_o=1 is ignored (no pulse, no state change).

Enqueue (key K latched on accept):
- Routing from IDLE:
  - full: go to EVICT_RD.
  - count==0: go to INS_WR with slot 0.
  - otherwise: go to INS_RD.
- EVICT_RD: read address DEPTH-1. EVICT compares the returned tail T with K:
  - K>=T: K itself is evicted; RAM untouched; return to IDLE after the handshake.
  - K<T: T is evicted; count is treated as DEPTH-1; go to INS_SCAN with pointer DEPTH-2, issuing that read in the same cycle.
- Eviction handshake: dn_write_o/dn_key_o held until dn_ready_i. With CHAIN_LAST=1, drop_o pulses instead and no dn handshake occurs.
- INS_RD: read pointer=count-1.
- INS_SCAN, each cycle:
  - If rdata>K: write rdata to pointer+1. If pointer>0, read pointer-1 in the same cycle and decrement the pointer. If pointer==0, go to INS_WR with slot 0.
  - If rdata<=K: go to INS_WR with slot pointer+1. Equal keys stay FIFO-ordered.
  - Throughput: 1 cycle per shifted entry.
- INS_WR: write K to the slot; count increments unless an eviction occurred; return to IDLE.

Dequeue:
- DEQ_RD: read address 0.
- Next cycle:
  - up_rd_valid_o pulses with up_rd_key_o=mem_rdata_i.
  - If count>1, read address 1 in that cycle and enter DEQ_SHIFT.
- DEQ_SHIFT: pipelined; write entry k to k-1 while reading k+1, through k=count-1.
- After the shift:
  - If CHAIN_LAST=0 and dn_empty_i=0: enter DEQ_FILL. dn_read_o is held until dn_ready_i, then the node waits for dn_rd_valid_i and writes dn_rd_key_i to address count-1. count is unchanged.
  - Otherwise: count decrements.

Status: count_o, full_o and empty_o are registered and update on the cycle the FSM returns to IDLE.

Decomposition:
- Package quickq_pkg holds:
  - the ctrl_state_t enum
  - a key_t typedef parametrised via the DATA_W default
  - the RAM read-latency constant RD_LAT=1
- Sub-module quickq_occ_ctr: up/down occupancy counter with inc, dec and async clear, producing count_o, full_o and empty_o.

Test Plan:
- Reset then enqueue 5, 3, 7 (DEPTH=8) -> RAM[0..2]=3,5,7; count_o=3. Enqueue of 3 takes 1 shift cycle.
- Fill with 1..8, then enqueue 0 -> dn_write_o with dn_key_o=8; RAM=0..7; full_o stays 1. Then enqueue 9 -> dn_key_o=9 with no RAM writes.
- With CHAIN_LAST=1 and the node full of 1..8, enqueue 4 -> drop_o pulse, RAM=1,2,3,4,4,5,6,7. The new 4 sits after the old 4.
- Node holds 2,4,6 with dn_empty_i=1; dequeue -> up_rd_valid_o with key 2 two cycles after accept; RAM=4,6; count_o=2.
- Node full of 1..8 with dn_empty_i=0; dequeue; respond dn_rd_valid_i with key 9 -> up_rd_key_o=1; RAM=2..9; count_o=8.
- up_read_i and up_write_i asserted together -> dequeue first. Then assert rst_n=0 mid-shift -> immediately up_ready_o=1, count_o=0, dn_* deasserted.

Source files
------------

// File: rtl/quickq_pkg.sv
// rtl/quickq_pkg.sv - shared types and constants for the QuickQ priority-queue stage
package quickq_pkg;

    localparam int KEY_W_DEF = 16;
    localparam int RD_LAT    = 1;

    typedef logic [KEY_W_DEF-1:0] key_t;

    typedef enum logic [3:0] {
        IDLE,
        EVICT_RD,
        EVICT,
        INS_RD,
        INS_SCAN,
        INS_WR,
        DEQ_RD,
        DEQ_SHIFT,
        DEQ_FILL
    } ctrl_state_t;

endpackage

// File: rtl/quickq_occ_ctr.sv
// rtl/quickq_occ_ctr.sv - registered up/down occupancy counter with full/empty flags
module quickq_occ_ctr #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [ADDR_W:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0] count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != DEPTH_C)) begin
            count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/quickq_ctrl_node.sv
// rtl/quickq_ctrl_node.sv - one QuickQ stage: sorted min-array in external RAM,
// insertion-sort enqueue with tail eviction, compacting dequeue with refill from the next stage
module quickq_ctrl_node
    import quickq_pkg::*;
#(
    parameter int   DATA_W     = 16,
    parameter int   DEPTH      = 8,
    localparam int  ADDR_W     = $clog2(DEPTH),
    parameter int   CHAIN_LAST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_write_i,
    input  logic [DATA_W-1:0] up_key_i,
    input  logic              up_read_i,
    output logic              up_ready_o,
    output logic              up_rd_valid_o,
    output logic [DATA_W-1:0] up_rd_key_o,
    output logic              dn_write_o,
    output logic [DATA_W-1:0] dn_key_o,
    output logic              dn_read_o,
    input  logic              dn_ready_i,
    input  logic              dn_rd_valid_i,
    input  logic [DATA_W-1:0] dn_rd_key_i,
    input  logic              dn_empty_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              drop_o
);

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] PENULT_A = ADDR_W'(DEPTH-2);

    ctrl_state_t       state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              evicted_q, evicted_d;
    logic              dn_write_q, dn_write_d;
    logic [DATA_W-1:0] dn_key_q, dn_key_d;
    logic              dn_read_q, dn_read_d;
    logic              cnt_inc, cnt_dec;
    logic [ADDR_W-1:0] tail_a;

    assign tail_a = ADDR_W'(count_o - 1'b1);

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        ptr_d         = ptr_q;
        evicted_d     = evicted_q;
        dn_write_d    = dn_write_q;
        dn_key_d      = dn_key_q;
        dn_read_d     = dn_read_q;
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wdata_o   = '0;
        up_rd_valid_o = 1'b0;
        up_rd_key_o   = '0;
        drop_o        = 1'b0;
        cnt_inc       = 1'b0;
        cnt_dec       = 1'b0;

        if (dn_write_q && dn_ready_i) dn_write_d = 1'b0;
        if (dn_read_q && dn_ready_i)  dn_read_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (up_read_i && !empty_o) begin
                    state_d = DEQ_RD;
                end else if (up_write_i) begin
                    key_d     = up_key_i;
                    evicted_d = 1'b0;
                    if (full_o) begin
                        state_d = EVICT_RD;
                    end else if (empty_o) begin
                        ptr_d   = '0;
                        state_d = INS_WR;
                    end else begin
                        state_d = INS_RD;
                    end
                end
            end
            EVICT_RD: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = LAST_A;
                state_d       = EVICT;
            end
            EVICT: begin
                // First EVICT cycle decides with the returned tail; later cycles only finish the handshake.
                if (!evicted_q) begin
                    evicted_d = 1'b1;
                    if (CHAIN_LAST != 0) begin
                        drop_o = 1'b1;
                    end else begin
                        dn_write_d = 1'b1;
                        dn_key_d   = (key_q >= mem_rdata_i) ? key_q : mem_rdata_i;
                    end
                    if (key_q < mem_rdata_i) begin
                        mem_rd_en_o   = 1'b1;
                        mem_rd_addr_o = PENULT_A;
                        ptr_d         = PENULT_A;
                        state_d       = INS_SCAN;
                    end else if (CHAIN_LAST != 0) begin
                        state_d = IDLE;
                    end
                end else if (!dn_write_q || dn_ready_i) begin
                    state_d = IDLE;
                end
            end
            INS_RD: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = tail_a;
                ptr_d         = tail_a;
                state_d       = INS_SCAN;
            end
            INS_SCAN: begin
                if (mem_rdata_i > key_q) begin
                    mem_wr_en_o   = 1'b1;
                    mem_wr_addr_o = ptr_q + 1'b1;
                    mem_wdata_o   = mem_rdata_i;
                    if (ptr_q != '0) begin
                        mem_rd_en_o   = 1'b1;
                        mem_rd_addr_o = ptr_q - 1'b1;
                        ptr_d         = ptr_q - 1'b1;
                    end else begin
                        ptr_d   = '0;
                        state_d = INS_WR;
                    end
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = INS_WR;
                end
            end
            INS_WR: begin
                mem_wr_en_o   = 1'b1;
                mem_wr_addr_o = ptr_q;
                mem_wdata_o   = key_q;
                if (!dn_write_q || dn_ready_i) begin
                    cnt_inc = !evicted_q;
                    state_d = IDLE;
                end
            end
            DEQ_RD: begin
                mem_rd_en_o   = 1'b1;
                mem_rd_addr_o = '0;
                ptr_d         = '0;
                state_d       = DEQ_SHIFT;
            end
            DEQ_SHIFT: begin
                // ptr_q is the address whose data is arriving; address 0 is the dequeued head.
                if (ptr_q == '0) begin
                    up_rd_valid_o = 1'b1;
                    up_rd_key_o   = mem_rdata_i;
                end else begin
                    mem_wr_en_o   = 1'b1;
                    mem_wr_addr_o = ptr_q - 1'b1;
                    mem_wdata_o   = mem_rdata_i;
                end
                if (({1'b0, ptr_q} + 1'b1) < count_o) begin
                    mem_rd_en_o   = 1'b1;
                    mem_rd_addr_o = ptr_q + 1'b1;
                    ptr_d         = ptr_q + 1'b1;
                end else if ((CHAIN_LAST == 0) && !dn_empty_i) begin
                    dn_read_d = 1'b1;
                    state_d   = DEQ_FILL;
                end else begin
                    cnt_dec = 1'b1;
                    state_d = IDLE;
                end
            end
            DEQ_FILL: begin
                if (!dn_read_q && dn_rd_valid_i) begin
                    mem_wr_en_o   = 1'b1;
                    mem_wr_addr_o = tail_a;
                    mem_wdata_o   = dn_rd_key_i;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            ptr_q      <= '0;
            evicted_q  <= 1'b0;
            dn_write_q <= 1'b0;
            dn_key_q   <= '0;
            dn_read_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ptr_q      <= ptr_d;
            evicted_q  <= evicted_d;
            dn_write_q <= dn_write_d;
            dn_key_q   <= dn_key_d;
            dn_read_q  <= dn_read_d;
        end
    end

    assign up_ready_o = (state_q == IDLE);
    assign dn_write_o = dn_write_q;
    assign dn_key_o   = dn_key_q;
    assign dn_read_o  = dn_read_q;

    quickq_occ_ctr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_occ (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

endmodule

// File: tb/tb_quickq_ctrl_node.sv
// tb/tb_quickq_ctrl_node.sv - self-checking bench for quickq_ctrl_node (chained and last-in-chain instances)
module tb_quickq_ctrl_node;

    localparam int DW  = 16;
    localparam int DEP = 8;
    localparam int AW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          up_write[2], up_read[2], up_ready[2], up_rd_valid[2];
    logic          dn_write[2], dn_read[2], dn_ready[2], dn_rd_valid[2], dn_empty[2];
    logic          mem_rd_en[2], mem_wr_en[2], full[2], empty[2], drop[2];
    logic [DW-1:0] up_key[2], up_rd_key[2], dn_key[2], dn_rd_key[2], mem_rdata[2], mem_wdata[2];
    logic [AW-1:0] mem_rd_addr[2], mem_wr_addr[2];
    logic [AW:0]   count[2];
    logic [DW-1:0] ram[2][DEP];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        quickq_ctrl_node #(.DATA_W(DW), .DEPTH(DEP), .CHAIN_LAST(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .up_write_i(up_write[g]), .up_key_i(up_key[g]), .up_read_i(up_read[g]),
            .up_ready_o(up_ready[g]), .up_rd_valid_o(up_rd_valid[g]), .up_rd_key_o(up_rd_key[g]),
            .dn_write_o(dn_write[g]), .dn_key_o(dn_key[g]), .dn_read_o(dn_read[g]),
            .dn_ready_i(dn_ready[g]), .dn_rd_valid_i(dn_rd_valid[g]), .dn_rd_key_i(dn_rd_key[g]),
            .dn_empty_i(dn_empty[g]),
            .mem_rd_en_o(mem_rd_en[g]), .mem_rd_addr_o(mem_rd_addr[g]), .mem_rdata_i(mem_rdata[g]),
            .mem_wr_en_o(mem_wr_en[g]), .mem_wr_addr_o(mem_wr_addr[g]), .mem_wdata_o(mem_wdata[g]),
            .count_o(count[g]), .full_o(full[g]), .empty_o(empty[g]), .drop_o(drop[g])
        );
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_wr_en[d]) ram[d][mem_wr_addr[d]] <= mem_wdata[d];
            if (mem_rd_en[d]) mem_rdata[d] <= ram[d][mem_rd_addr[d]];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    // reference model: sorted list of keys currently held by the node under test
    logic [DW-1:0] mq[$];

    bit            got_rd, timeout;
    logic [DW-1:0] rd_key, ev_key;
    int            rd_cyc, ev_n, drop_n, wr_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_ins(input logic [DW-1:0] k);
        int pos = 0;
        foreach (mq[i]) if (mq[i] <= k) pos++;
        mq.insert(pos, k);
    endtask

    task automatic run_op(input int d, input bit rd, input bit wr, input logic [DW-1:0] k,
                          input logic [DW-1:0] rf);
        int cyc, rf_at;
        got_rd = 0; rd_key = '0; rd_cyc = -1; ev_n = 0; ev_key = '0; drop_n = 0; wr_n = 0; rf_at = -1;
        up_read[d] = rd; up_write[d] = wr; up_key[d] = k;
        @(negedge clk);
        up_read[d] = 1'b0; up_write[d] = 1'b0;
        cyc = 1;
        forever begin
            dn_rd_valid[d] = (cyc == rf_at);
            dn_rd_key[d]   = rf;
            dn_ready[d]    = ($urandom_range(0, 2) != 0);
            if (up_rd_valid[d]) begin got_rd = 1; rd_key = up_rd_key[d]; rd_cyc = cyc; end
            if (drop[d]) drop_n++;
            if (mem_wr_en[d]) wr_n++;
            if (dn_write[d] && dn_ready[d]) begin ev_n++; ev_key = dn_key[d]; end
            if (dn_read[d] && dn_ready[d]) rf_at = cyc + 2;
            if (up_ready[d] || cyc > 200) break;
            @(negedge clk);
            cyc++;
        end
        dn_rd_valid[d] = 1'b0;
        timeout = (cyc > 200);
    endtask

    task automatic step(input int d, input bit rd, input bit wr, input logic [DW-1:0] k,
                        input bit demp, input logic [DW-1:0] rf);
        bit            e_rd = 0;
        logic [DW-1:0] e_rk = '0, e_ev = '0;
        int            e_evn = 0, e_drop = 0;
        if (rd && mq.size() > 0) begin
            e_rd = 1;
            e_rk = mq.pop_front();
            if (d == 0 && !demp) mq.push_back(rf);
        end else if (wr) begin
            if (mq.size() == DEP) begin
                if (k >= mq[DEP-1]) e_ev = k;
                else begin e_ev = mq.pop_back(); m_ins(k); end
                if (d == 1) e_drop = 1; else e_evn = 1;
            end else begin
                m_ins(k);
            end
        end
        dn_empty[d] = demp;
        run_op(d, rd, wr, k, rf);
        chk("timeout", 32'(timeout), 0);
        chk("rd_valid", 32'(got_rd), 32'(e_rd));
        if (e_rd) begin
            chk("rd_key", 32'(rd_key), 32'(e_rk));
            chk("rd_latency", rd_cyc, 2);
        end
        chk("evict_cnt", ev_n, e_evn);
        if (e_evn != 0) chk("evict_key", 32'(ev_key), 32'(e_ev));
        chk("drop_cnt", drop_n, e_drop);
        chk("count", 32'(count[d]), mq.size());
        chk("full", 32'(full[d]), 32'(mq.size() == DEP));
        chk("empty", 32'(empty[d]), 32'(mq.size() == 0));
        foreach (mq[i]) chk($sformatf("ram[%0d]", i), 32'(ram[d][i]), 32'(mq[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            up_write[d] = 0; up_read[d] = 0; up_key[d] = '0;
            dn_ready[d] = 0; dn_rd_valid[d] = 0; dn_rd_key[d] = '0; dn_empty[d] = 1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(up_ready[d]), 1);
            chk("rst_empty", 32'(empty[d]), 1);
            chk("rst_full", 32'(full[d]), 0);
            chk("rst_count", 32'(count[d]), 0);
            chk("rst_dn_write", 32'(dn_write[d]), 0);
            chk("rst_dn_read", 32'(dn_read[d]), 0);
            chk("rst_mem_wr", 32'(mem_wr_en[d]), 0);
            chk("rst_drop", 32'(drop[d]), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // last-in-chain node: full of 1..8, enqueue 4 drops the tail
        mq.delete();
        for (int i = 1; i <= 8; i++) step(1, 0, 1, DW'(i), 1, '0);
        step(1, 0, 1, 16'd4, 1, '0);
        chk("cl1_drop", drop_n, 1);
        chk("cl1_ram4", 32'(ram[1][4]), 4);
        chk("cl1_ram7", 32'(ram[1][7]), 7);
        mq.delete();

        // chained node: basic insertion sort
        step(0, 0, 1, 16'd5, 1, '0);
        step(0, 0, 1, 16'd3, 1, '0);
        chk("ins3_writes", wr_n, 2);
        step(0, 0, 1, 16'd7, 1, '0);
        chk("ram0_is3", 32'(ram[0][0]), 3);
        chk("ram1_is5", 32'(ram[0][1]), 5);
        chk("ram2_is7", 32'(ram[0][2]), 7);
        while (mq.size() > 0) step(0, 1, 0, '0, 1, '0);

        // eviction to next stage
        for (int i = 1; i <= 8; i++) step(0, 0, 1, DW'(i), 1, '0);
        step(0, 0, 1, 16'd0, 1, '0);
        chk("ev0_key", 32'(ev_key), 8);
        chk("ev0_full", 32'(full[0]), 1);
        step(0, 0, 1, 16'd9, 1, '0);
        chk("ev9_key", 32'(ev_key), 9);
        chk("ev9_no_writes", wr_n, 0);

        // dequeue with refill from the next stage
        step(0, 1, 0, '0, 1, '0);
        step(0, 0, 1, 16'd8, 1, '0);
        step(0, 1, 0, '0, 0, 16'd9);
        chk("refill_rdkey", 32'(rd_key), 1);
        chk("refill_tail", 32'(ram[0][7]), 9);
        chk("refill_count", 32'(count[0]), 8);

        // dequeue latency without refill
        while (mq.size() > 0) step(0, 1, 0, '0, 1, '0);
        step(0, 0, 1, 16'd6, 1, '0);
        step(0, 0, 1, 16'd2, 1, '0);
        step(0, 0, 1, 16'd4, 1, '0);
        step(0, 1, 0, '0, 1, '0);
        chk("deq_key2", 32'(rd_key), 2);
        chk("deq_cyc", rd_cyc, 2);
        chk("deq_count2", 32'(count[0]), 2);

        // read on empty is ignored; simultaneous read/write favours read
        while (mq.size() > 0) step(0, 1, 0, '0, 1, '0);
        step(0, 1, 0, '0, 1, '0);
        step(0, 1, 1, 16'd11, 1, '0);
        step(0, 1, 1, 16'd12, 1, '0);
        chk("rdwr_key", 32'(rd_key), 11);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                step(0, 0, 1, DW'($urandom_range(0, 40)), 1, '0);
            end else begin
                step(0, 1, 0, '0, 1'($urandom_range(0, 1)),
                     DW'((mq.size() > 0 ? mq[mq.size()-1] : 16'd0) + DW'($urandom_range(0, 5))));
            end
        end

        // asynchronous reset in the middle of a dequeue shift
        while (mq.size() < DEP) step(0, 0, 1, DW'($urandom_range(0, 40)), 1, '0);
        dn_empty[0] = 1'b0;
        up_read[0] = 1'b1;
        @(negedge clk);
        up_read[0] = 1'b0;
        for (int i = 0; i < 20 && !mem_wr_en[0]; i++) @(negedge clk);
        chk("mid_shift_reached", 32'(mem_wr_en[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(up_ready[0]), 1);
        chk("arst_count", 32'(count[0]), 0);
        chk("arst_empty", 32'(empty[0]), 1);
        chk("arst_dn_read", 32'(dn_read[0]), 0);
        chk("arst_dn_write", 32'(dn_write[0]), 0);
        chk("arst_mem_wr", 32'(mem_wr_en[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
        step(0, 0, 1, 16'd21, 1, '0);
        step(0, 1, 0, '0, 1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
